// File: rtl/ula_controlador_8bits_pkg.sv
// Shared definitions for the ula_8bits command front-end: opcodes, error codes,
// controller state encoding and the opcode legality helper.
// Optional build macro ULA_CTRL_ACUMULADOR_EN is consumed by the interface and top.
package ula_pkg;

  localparam logic [3:0] OP_SOMA  = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_RESTO = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_NULO  = 4'b1111;

  localparam logic [1:0] ERRO_OK     = 2'b00;
  localparam logic [1:0] ERRO_OPCODE = 2'b01;
  localparam logic [1:0] ERRO_DIV0   = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    EXECUTA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  // 0101 is a hole in the opcode map; 1100..1111 are unassigned (1111 is the
  // idle/null code the controller parks on, never a legal command).
  function automatic logic opcode_ilegal(input logic [3:0] op);
    return (op == 4'b0101) || (op >= 4'b1100);
  endfunction

endpackage

// File: rtl/ula_controlador_8bits_if.sv
// Bundle of the command, ALU and result buses of ula_controlador_8bits.
// master = command issuer / ALU / result consumer side, slave = the controller.
// Cmd_Acc exists only when ULA_CTRL_ACUMULADOR_EN is defined.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready are
// both 1; valid, once raised, holds its payload stable until that edge, and ready
// may be driven independently of valid.
interface ula_controlador_8bits_if;
  import ula_pkg::*;

  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [3:0]  Cmd_Op;
  logic [7:0]  Cmd_A;
  logic [7:0]  Cmd_B;
`ifdef ULA_CTRL_ACUMULADOR_EN
  logic        Cmd_Acc;
`endif
  logic [7:0]  Ula_A;
  logic [7:0]  Ula_B;
  logic [3:0]  Ula_Sel_Op;
  logic [15:0] Ula_Resultado;
  logic        Ula_Maior;
  logic        Ula_Menor;
  logic        Ula_Igual;
  logic        Res_Valid;
  logic        Res_Ready;
  logic [15:0] Res_Dado;
  logic [2:0]  Res_Flags;
  logic [1:0]  Res_Erro;
  estado_t     estado;

  modport master (
`ifdef ULA_CTRL_ACUMULADOR_EN
    output Cmd_Acc,
`endif
    output Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B,
    input  Cmd_Ready,
    input  Ula_A, Ula_B, Ula_Sel_Op,
    output Ula_Resultado, Ula_Maior, Ula_Menor, Ula_Igual,
    input  Res_Valid, Res_Dado, Res_Flags, Res_Erro,
    output Res_Ready,
    input  estado
  );

  modport slave (
`ifdef ULA_CTRL_ACUMULADOR_EN
    input  Cmd_Acc,
`endif
    input  Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B,
    output Cmd_Ready,
    output Ula_A, Ula_B, Ula_Sel_Op,
    input  Ula_Resultado, Ula_Maior, Ula_Menor, Ula_Igual,
    output Res_Valid, Res_Dado, Res_Flags, Res_Erro,
    input  Res_Ready,
    output estado
  );
endinterface

// File: rtl/ula_ctrl_decod.sv
// Combinational command check: flags illegal opcodes and division/remainder by zero.
module ula_ctrl_decod
  import ula_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] b,
  output logic       ilegal,
  output logic       div_zero
);

  // Illegal opcode is reported separately; the top gives it priority.
  assign ilegal   = opcode_ilegal(op);
  assign div_zero = ((op == OP_DIV) || (op == OP_RESTO)) && (b == 8'd0);

endmodule

// File: rtl/ula_controlador_8bits.sv
// Command front-end for ula_8bits: accepts one operation, drives the ALU inputs,
// waits LATENCIA cycles (1..15), captures result and flags, and returns them.
// Rejected commands (illegal opcode, divide by zero) never touch the ALU inputs.
// Build option ULA_CTRL_ACUMULADOR_EN adds Cmd_Acc and an 8-bit accumulator that
// can stand in for operand A.
module ula_controlador_8bits
  import ula_pkg::*;
#(
  parameter int LATENCIA = 1
) (
  input logic                     Clk,
  input logic                     Rst,
  ula_controlador_8bits_if.slave  bus
);

  localparam logic [3:0] LAT = 4'(LATENCIA);

  estado_t     estado;
  logic [3:0]  contador;
  logic        cmd_ready;
  logic        res_valid;
  logic [15:0] res_dado;
  logic [2:0]  res_flags;
  logic [1:0]  res_erro;
  logic [7:0]  ula_a;
  logic [7:0]  ula_b;
  logic [3:0]  ula_sel_op;
  logic [7:0]  op_a;
  logic        ilegal;
  logic        div_zero;

`ifdef ULA_CTRL_ACUMULADOR_EN
  logic [7:0] acumulador;
  // Operand A source: accumulator when requested, otherwise the command field.
  assign op_a = bus.Cmd_Acc ? acumulador : bus.Cmd_A;
`else
  assign op_a = bus.Cmd_A;
`endif

  ula_ctrl_decod u_decod (
    .op       (bus.Cmd_Op),
    .b        (bus.Cmd_B),
    .ilegal   (ilegal),
    .div_zero (div_zero)
  );

  // Controller FSM: idle -> execute (settle countdown) -> result handshake.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      estado     <= OCIOSO;
      contador   <= 4'd0;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_dado   <= 16'd0;
      res_flags  <= 3'b000;
      res_erro   <= ERRO_OK;
      ula_a      <= 8'd0;
      ula_b      <= 8'd0;
      ula_sel_op <= OP_NULO;
`ifdef ULA_CTRL_ACUMULADOR_EN
      acumulador <= 8'd0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.Cmd_Valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (ilegal || div_zero) begin
              // Answer straight away with an error; the ALU stays on the null opcode.
              res_dado  <= 16'd0;
              res_flags <= 3'b000;
              res_erro  <= ilegal ? ERRO_OPCODE : ERRO_DIV0;
              res_valid <= 1'b1;
              estado    <= RESULTADO;
            end else begin
              ula_a      <= op_a;
              ula_b      <= bus.Cmd_B;
              ula_sel_op <= bus.Cmd_Op;
              contador   <= LAT;
              estado     <= EXECUTA;
            end
          end
        end
        EXECUTA: begin
          if (contador == 4'd1) begin
            res_dado   <= bus.Ula_Resultado;
            res_flags  <= {bus.Ula_Maior, bus.Ula_Menor, bus.Ula_Igual};
            res_erro   <= ERRO_OK;
            res_valid  <= 1'b1;
            ula_sel_op <= OP_NULO;
            contador   <= 4'd0;
            estado     <= RESULTADO;
          end else begin
            contador <= contador - 4'd1;
          end
        end
        RESULTADO: begin
          // Payload is held until the consumer takes it; ready returns one cycle later.
          if (res_valid && bus.Res_Ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            estado    <= OCIOSO;
`ifdef ULA_CTRL_ACUMULADOR_EN
            if (res_erro == ERRO_OK) acumulador <= res_dado[7:0];
`endif
          end
        end
        default: begin
          estado    <= OCIOSO;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Cmd_Ready  = cmd_ready;
  assign bus.Res_Valid  = res_valid;
  assign bus.Res_Dado   = res_dado;
  assign bus.Res_Flags  = res_flags;
  assign bus.Res_Erro   = res_erro;
  assign bus.Ula_A      = ula_a;
  assign bus.Ula_B      = ula_b;
  assign bus.Ula_Sel_Op = ula_sel_op;
  assign bus.estado     = estado;

endmodule

// File: tb/tb_ula_controlador_8bits.sv
// Directed bench for ula_controlador_8bits with a behavioural ula_8bits on each
// controller. Three controllers (LATENCIA 1, 3, 4) share the stimulus; sel picks
// the one that receives Cmd_Valid and whose outputs are observed.
module tb_ula_controlador_8bits;
  import ula_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  int         sel;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       res_ready;

  int n_vec = 0;
  int n_err = 0;

  ula_controlador_8bits_if if1 ();
  ula_controlador_8bits_if if3 ();
  ula_controlador_8bits_if if4 ();

  ula_controlador_8bits #(.LATENCIA(1)) dut1 (.Clk(clk), .Rst(rst), .bus(if1.slave));
  ula_controlador_8bits #(.LATENCIA(3)) dut3 (.Clk(clk), .Rst(rst), .bus(if3.slave));
  ula_controlador_8bits #(.LATENCIA(4)) dut4 (.Clk(clk), .Rst(rst), .bus(if4.slave));

  // Behavioural ula_8bits: 8-bit arithmetic/logic zero-extended, 16-bit product.
  function automatic logic [18:0] ula_modelo(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    logic [15:0] r;
    r = 16'd0;
    case (op)
      OP_SOMA:  r = {8'd0, 8'(a + b)};
      OP_SUB:   r = {8'd0, 8'(a - b)};
      OP_MUL:   r = 16'(a) * 16'(b);
      OP_DIV:   r = (b != 0) ? {8'd0, 8'(a / b)} : 16'd0;
      OP_RESTO: r = (b != 0) ? {8'd0, 8'(a % b)} : 16'd0;
      OP_AND:   r = {8'd0, a & b};
      OP_OR:    r = {8'd0, a | b};
      OP_NAND:  r = {8'd0, ~(a & b)};
      OP_NOR:   r = {8'd0, ~(a | b)};
      OP_XOR:   r = {8'd0, a ^ b};
      OP_NOT:   r = {8'd0, ~a};
      default:  r = 16'd0;
    endcase
    return {a > b, a < b, a == b, r};
  endfunction

  assign {if1.Ula_Maior, if1.Ula_Menor, if1.Ula_Igual, if1.Ula_Resultado} =
         ula_modelo(if1.Ula_Sel_Op, if1.Ula_A, if1.Ula_B);
  assign {if3.Ula_Maior, if3.Ula_Menor, if3.Ula_Igual, if3.Ula_Resultado} =
         ula_modelo(if3.Ula_Sel_Op, if3.Ula_A, if3.Ula_B);
  assign {if4.Ula_Maior, if4.Ula_Menor, if4.Ula_Igual, if4.Ula_Resultado} =
         ula_modelo(if4.Ula_Sel_Op, if4.Ula_A, if4.Ula_B);

  assign if1.Cmd_Valid = cmd_valid && (sel == 1);
  assign if3.Cmd_Valid = cmd_valid && (sel == 3);
  assign if4.Cmd_Valid = cmd_valid && (sel == 4);
  assign if1.Cmd_Op = cmd_op;  assign if1.Cmd_A = cmd_a;  assign if1.Cmd_B = cmd_b;
  assign if3.Cmd_Op = cmd_op;  assign if3.Cmd_A = cmd_a;  assign if3.Cmd_B = cmd_b;
  assign if4.Cmd_Op = cmd_op;  assign if4.Cmd_A = cmd_a;  assign if4.Cmd_B = cmd_b;
  assign if1.Res_Ready = res_ready;
  assign if3.Res_Ready = res_ready;
  assign if4.Res_Ready = res_ready;
`ifdef ULA_CTRL_ACUMULADOR_EN
  assign if1.Cmd_Acc = 1'b0;
  assign if3.Cmd_Acc = 1'b0;
  assign if4.Cmd_Acc = 1'b0;
`endif

  // ---------------- observation mux ----------------
  logic        o_ready, o_valid;
  logic [15:0] o_dado;
  logic [2:0]  o_flags;
  logic [1:0]  o_erro;
  logic [7:0]  o_ula_a, o_ula_b;
  logic [3:0]  o_sel_op;
  estado_t     o_estado;

  always_comb begin
    o_ready = if1.Cmd_Ready;  o_valid = if1.Res_Valid;  o_dado = if1.Res_Dado;
    o_flags = if1.Res_Flags;  o_erro = if1.Res_Erro;    o_ula_a = if1.Ula_A;
    o_ula_b = if1.Ula_B;      o_sel_op = if1.Ula_Sel_Op; o_estado = if1.estado;
    if (sel == 3) begin
      o_ready = if3.Cmd_Ready;  o_valid = if3.Res_Valid;  o_dado = if3.Res_Dado;
      o_flags = if3.Res_Flags;  o_erro = if3.Res_Erro;    o_ula_a = if3.Ula_A;
      o_ula_b = if3.Ula_B;      o_sel_op = if3.Ula_Sel_Op; o_estado = if3.estado;
    end else if (sel == 4) begin
      o_ready = if4.Cmd_Ready;  o_valid = if4.Res_Valid;  o_dado = if4.Res_Dado;
      o_flags = if4.Res_Flags;  o_erro = if4.Res_Erro;    o_ula_a = if4.Ula_A;
      o_ula_b = if4.Ula_B;      o_sel_op = if4.Ula_Sel_Op; o_estado = if4.estado;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits for Cmd_Ready, presents one command, returns at the negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_before_send", 32'(o_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Edges after acceptance until Res_Valid is seen (bounded).
  task automatic wait_res(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with Res_Ready held high; exp_lat=0 means immediate error reply.
  task automatic op_check(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [15:0] exp_dado,
                          input logic [2:0] exp_flags, input logic [1:0] exp_erro);
    int lat;
    res_ready = 1'b1;
    send(op, a, b);
    check({tag, "_ula_sel_drive"}, 32'(o_sel_op), (exp_lat == 0) ? 32'(OP_NULO) : 32'(op));
    wait_res(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dado"}, 32'(o_dado), 32'(exp_dado));
    check({tag, "_flags"}, 32'(o_flags), 32'(exp_flags));
    check({tag, "_erro"}, 32'(o_erro), 32'(exp_erro));
    check({tag, "_ula_sel_park"}, 32'(o_sel_op), 32'(OP_NULO));
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_res_dado"}, 32'(o_dado), 32'd0);
    check({tag, "_res_flags"}, 32'(o_flags), 32'd0);
    check({tag, "_res_erro"}, 32'(o_erro), 32'd0);
    check({tag, "_ula_a"}, 32'(o_ula_a), 32'd0);
    check({tag, "_ula_b"}, 32'(o_ula_b), 32'd0);
    check({tag, "_ula_sel"}, 32'(o_sel_op), 32'hF);
    check({tag, "_estado"}, 32'(o_estado), 32'(OCIOSO));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    sel       = 1;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // LATENCIA=1 directed vectors
    op_check("add_200_100",  OP_SOMA,  8'd200, 8'd100, 1, 16'h002C, 3'b100, ERRO_OK);
    op_check("mul_255_255",  OP_MUL,   8'd255, 8'd255, 1, 16'hFE01, 3'b001, ERRO_OK);
    op_check("illegal_0101", 4'b0101,  8'd7,   8'd3,   0, 16'h0000, 3'b000, ERRO_OPCODE);
    op_check("div_9_0",      OP_DIV,   8'd9,   8'd0,   0, 16'h0000, 3'b000, ERRO_DIV0);
    op_check("resto_9_4",    OP_RESTO, 8'd9,   8'd4,   1, 16'h0001, 3'b100, ERRO_OK);
    op_check("illegal_pri",  4'b1100,  8'd9,   8'd0,   0, 16'h0000, 3'b000, ERRO_OPCODE);
    op_check("illegal_1111", 4'b1111,  8'd1,   8'd1,   0, 16'h0000, 3'b000, ERRO_OPCODE);
    op_check("resto_5_0",    OP_RESTO, 8'd5,   8'd0,   0, 16'h0000, 3'b000, ERRO_DIV0);
    op_check("div_200_7",    OP_DIV,   8'd200, 8'd7,   1, 16'h001C, 3'b100, ERRO_OK);
    op_check("not_0f",       OP_NOT,   8'h0F,  8'h00,  1, 16'h00F0, 3'b100, ERRO_OK);
    op_check("xor_eq",       OP_XOR,   8'h5A,  8'h5A,  1, 16'h0000, 3'b001, ERRO_OK);

    // LATENCIA=4
    sel = 4;
    @(negedge clk);
    op_check("mul_lat4",     OP_MUL,   8'd255, 8'd255, 4, 16'hFE01, 3'b001, ERRO_OK);

    // Backpressure on LATENCIA=1 with ignored command pulses
    sel = 1;
    res_ready = 1'b0;
    send(OP_SUB, 8'd5, 8'd9);
    wait_res(seen);
    check("bp_latency", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      cmd_op    = OP_SOMA;
      cmd_a     = 8'd77;
      cmd_b     = 8'd11;
      @(negedge clk);
      check("bp_dado", 32'(o_dado), 32'h00FC);
      check("bp_flags", 32'(o_flags), 32'b010);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_cmd_ready", 32'(o_ready), 32'd0);
      check("bp_ula_sel", 32'(o_sel_op), 32'(OP_NULO));
      check("bp_ula_a", 32'(o_ula_a), 32'd5);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 32'(o_valid), 32'd0);
    check("bp_ready_back", 32'(o_ready), 32'd1);

    // Reset in the middle of EXECUTA, LATENCIA=3
    sel = 3;
    @(negedge clk);
    send(OP_SOMA, 8'd1, 8'd2);
    check("midrst_in_exec", 32'(o_estado), 32'(EXECUTA));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    op_check("add_lat3",     OP_SOMA,  8'd3,   8'd4,   3, 16'h0007, 3'b010, ERRO_OK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
